// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson-code receive path.
//   JCODE_W  : width of a Johnson code word (8-bit twisted ring)
//   JIDX_W   : width of the decoded phase index (16 phases)
//   ERRCNT_W : width of the saturating error counter
//   jstate_t : lock/unlock sequence tracker states
package johnson_pkg;

  localparam int unsigned JCODE_W  = 8;
  localparam int unsigned JIDX_W   = 4;
  localparam int unsigned ERRCNT_W = 8;

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRE,
    LOCKED
  } jstate_t;

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson code word decoder.
//   code  in  [7:0] Johnson code word, bit 0 is the ring input end
//   idx   out [3:0] decoded phase 0..15 (meaningful only when legal)
//   legal out       word is one of the 16 legal Johnson codes
module johnson_code_decode
  import johnson_pkg::*;
(
  input  logic [JCODE_W-1:0] code,
  output logic [JIDX_W-1:0]  idx,
  output logic               legal
);

  logic [3:0] ones;
  logic [2:0] edges;

  // A legal word is a single run of ones against a single run of zeros,
  // so it has at most one 0/1 boundary between adjacent bits.
  always_comb begin
    ones  = '0;
    edges = '0;
    for (int unsigned i = 0; i < JCODE_W; i++) begin
      ones = ones + {3'b000, code[i]};
    end
    for (int unsigned i = 0; i < JCODE_W - 1; i++) begin
      edges = edges + {2'b00, code[i] ^ code[i+1]};
    end
    legal = (edges <= 3'd1);
    // Filling phase (ones grow from bit 0) counts up; draining phase
    // (zeros grow from bit 0) counts from the top of the ring.
    if (code[0] || (code == '0)) begin
      idx = ones;
    end else begin
      idx = 4'(5'd16 - {1'b0, ones});
    end
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson code receiver: decodes sampled words to a phase index, flags
// illegal words and sequence errors, and tracks lock on the +1 sequence.
//   clk         in       system clock, rising edge
//   reset       in       asynchronous active-high reset
//   clear       in       synchronous clear of err_count (wins over increment)
//   code_valid  in       qualifies code this cycle
//   code        in  [7:0] Johnson code word
//   index       out [3:0] phase of last legal sample
//   index_valid out      pulse: index updated
//   code_err    out      pulse: sampled word illegal
//   seq_err     out      pulse: legal word but wrong step
//   locked      out      FSM is in LOCKED
//   err_count   out [7:0] saturating count of code_err + seq_err
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned MISS_LIMIT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                code_valid,
  input  logic [JCODE_W-1:0]  code,
  output logic [JIDX_W-1:0]   index,
  output logic                index_valid,
  output logic                code_err,
  output logic                seq_err,
  output logic                locked,
  output logic [ERRCNT_W-1:0] err_count
);

  jstate_t           state, state_n;
  logic [3:0]        step, step_n;
  logic [3:0]        miss, miss_n;
  logic [JIDX_W-1:0] index_n;
  logic              index_valid_n, code_err_n, seq_err_n;

  logic [JIDX_W-1:0] dec_idx;
  logic              dec_legal;
  logic [JIDX_W-1:0] expected;

  johnson_code_decode u_decode (
    .code  (code),
    .idx   (dec_idx),
    .legal (dec_legal)
  );

  assign expected = index + 4'd1;

  always_comb begin
    state_n       = state;
    step_n        = step;
    miss_n        = miss;
    index_n       = index;
    index_valid_n = 1'b0;
    code_err_n    = 1'b0;
    seq_err_n     = 1'b0;

    if (code_valid) begin
      if (!dec_legal) begin
        code_err_n = 1'b1;
        unique case (state)
          ACQUIRE: begin
            state_n = UNLOCKED;
            step_n  = '0;
          end
          LOCKED: begin
            if (miss + 4'd1 >= 4'(MISS_LIMIT)) begin
              state_n = UNLOCKED;
              miss_n  = '0;
            end else begin
              miss_n = miss + 4'd1;
            end
          end
          default: ;
        endcase
      end else begin
        index_valid_n = 1'b1;
        index_n       = dec_idx;
        unique case (state)
          UNLOCKED: begin
            state_n = ACQUIRE;
            step_n  = '0;
          end
          ACQUIRE: begin
            if (dec_idx == expected) begin
              if (step + 4'd1 >= 4'(LOCK_COUNT)) begin
                state_n = LOCKED;
                step_n  = '0;
                miss_n  = '0;
              end else begin
                step_n = step + 4'd1;
              end
            end else if (dec_idx != index) begin
              seq_err_n = 1'b1;
              step_n    = '0;
            end
          end
          LOCKED: begin
            if ((dec_idx == expected) || (dec_idx == index)) begin
              miss_n = '0;
            end else begin
              seq_err_n = 1'b1;
              if (miss + 4'd1 >= 4'(MISS_LIMIT)) begin
                state_n = UNLOCKED;
                miss_n  = '0;
              end else begin
                miss_n = miss + 4'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= UNLOCKED;
      step        <= '0;
      miss        <= '0;
      index       <= '0;
      index_valid <= 1'b0;
      code_err    <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      state       <= state_n;
      step        <= step_n;
      miss        <= miss_n;
      index       <= index_n;
      index_valid <= index_valid_n;
      code_err    <= code_err_n;
      seq_err     <= seq_err_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (clear) begin
      err_count <= '0;
    end else if ((code_err_n || seq_err_n) && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_johnson_decoder.sv
module tb_johnson_decoder;

  localparam int LC = 4;
  localparam int ML = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       code_valid = 1'b0;
  logic [7:0] code = 8'h00;
  logic [3:0] index;
  logic       index_valid, code_err, seq_err, locked;
  logic [7:0] err_count;

  johnson_decoder #(.LOCK_COUNT(LC), .MISS_LIMIT(ML)) dut (
    .clk(clk), .reset(reset), .clear(clear), .code_valid(code_valid),
    .code(code), .index(index), .index_valid(index_valid),
    .code_err(code_err), .seq_err(seq_err), .locked(locked),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx; int iv; int ce; int se; int lk; int ec;
  } exp_t;

  exp_t sbq[$];
  int compares = 0;
  int errors = 0;

  // Reference: the 16 legal words built from the run-of-ones definition.
  logic [7:0] jc[16];
  // Model state: 0 = unlocked, 1 = acquiring, 2 = locked.
  int mst, mlast, mstep, mmiss, merr;

  function automatic void chk(string nm, logic [8:0] act, logic [8:0] want);
    compares++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, want, $time);
    end
  endfunction

  function automatic int ref_decode(logic [7:0] w);
    for (int k = 0; k < 16; k++) if (jc[k] == w) return k;
    return -1;
  endfunction

  function automatic void model_reset();
    mst = 0; mlast = 0; mstep = 0; mmiss = 0; merr = 0;
  endfunction

  function automatic void model_step(bit v, logic [7:0] w, bit clr);
    exp_t e;
    int k;
    e.iv = 0; e.ce = 0; e.se = 0;
    if (v) begin
      k = ref_decode(w);
      if (k < 0) begin
        e.ce = 1;
        if (mst == 1) begin mst = 0; mstep = 0; end
        else if (mst == 2) begin
          mmiss++;
          if (mmiss >= ML) begin mst = 0; mmiss = 0; end
        end
      end else begin
        e.iv = 1;
        if (mst == 0) begin
          mst = 1; mstep = 0;
        end else if (mst == 1) begin
          if (k == (mlast + 1) % 16) begin
            mstep++;
            if (mstep >= LC) begin mst = 2; mstep = 0; mmiss = 0; end
          end else if (k != mlast) begin
            e.se = 1; mstep = 0;
          end
        end else begin
          if (k == (mlast + 1) % 16 || k == mlast) mmiss = 0;
          else begin
            e.se = 1; mmiss++;
            if (mmiss >= ML) begin mst = 0; mmiss = 0; end
          end
        end
        mlast = k;
      end
    end
    if (clr) merr = 0;
    else if ((e.ce || e.se) && merr < 255) merr++;
    e.idx = mlast; e.lk = (mst == 2); e.ec = merr;
    sbq.push_back(e);
  endfunction

  task automatic drive(bit v, logic [7:0] w, bit clr);
    @(negedge clk);
    code_valid = v; code = w; clear = clr;
    model_step(v, w, clr);
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk); n++;
    end
    if (sbq.size() != 0) begin
      compares++; errors++;
      $display("FAIL drain_timeout actual=%0d expected=0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_index"}, 9'(index), 9'd0);
    chk({tag, "_index_valid"}, 9'(index_valid), 9'd0);
    chk({tag, "_code_err"}, 9'(code_err), 9'd0);
    chk({tag, "_seq_err"}, 9'(seq_err), 9'd0);
    chk({tag, "_locked"}, 9'(locked), 9'd0);
    chk({tag, "_err_count"}, 9'(err_count), 9'd0);
  endtask

  // Monitor: one expected entry per driven cycle, compared after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("index", 9'(index), 9'(e.idx));
        chk("index_valid", 9'(index_valid), 9'(e.iv));
        chk("code_err", 9'(code_err), 9'(e.ce));
        chk("seq_err", 9'(seq_err), 9'(e.se));
        chk("locked", 9'(locked), 9'(e.lk));
        chk("err_count", 9'(err_count), 9'(e.ec));
        if (code_err && seq_err) begin
          compares++; errors++;
          $display("FAIL both_errs actual=1 expected=0");
        end
      end
    end
  end

  initial begin
    logic [7:0] w;
    int r;
    for (int k = 0; k < 16; k++) begin
      if (k <= 8) jc[k] = 8'((9'd1 << k) - 9'd1);
      else        jc[k] = 8'(8'hFF << (k - 8));
    end
    model_reset();

    // Asynchronous reset before any clock edge.
    #3 reset = 1'b1;
    #1 check_all_zero("rst_async");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Full walk 0..15 then wrap to 0.
    for (int k = 0; k < 17; k++) drive(1'b1, jc[k % 16], 1'b0);
    // Illegal word while locked.
    drive(1'b1, 8'h5A, 1'b0);
    // Recover to index 3, then skip twice.
    for (int k = 1; k <= 3; k++) drive(1'b1, jc[k], 1'b0);
    drive(1'b1, 8'h1F, 1'b0);
    drive(1'b1, 8'h7F, 1'b0);
    // Holds: no errors.
    for (int i = 0; i < 5; i++) drive(1'b1, 8'h7F, 1'b0);
    idle();
    // Saturation.
    for (int i = 0; i < 300; i++) drive(1'b1, 8'h5A, 1'b0);
    // clear wins over an error in the same cycle.
    drive(1'b1, 8'h5A, 1'b1);
    idle();

    // Lock, then reset mid-lock.
    for (int k = 0; k < 6; k++) drive(1'b1, jc[k], 1'b0);
    idle();
    drain();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("midlock_locked", 9'(locked), 9'd0);
    check_all_zero("rst_midlock");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    // Relock needs four fresh steps from a new start.
    for (int k = 9; k < 16; k++) drive(1'b1, jc[k], 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      w = jc[(mlast + 1) % 16];
      else if (r < 70) w = jc[mlast];
      else if (r < 80) w = jc[$urandom_range(0, 15)];
      else             w = 8'($urandom_range(0, 255));
      drive(r < 92, w, $urandom_range(0, 99) < 2);
    end
    idle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
